// File: rtl/fpu_pattern_engine_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pattern_engine_pkg
//   Shared types and constants for the FPU pattern engine: FSM state
//   encoding, operand-mode codes, the LFSR feedback mask, the saturating
//   counter helper and the bit layout of one capture record.
//
//   Capture record layout, MSB to LSB, for operand width w:
//     A [w] | B [w] | Sel [2] | round [2] | Error | Overflow | Y [w]
// ---------------------------------------------------------------------------
package fpu_pattern_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GEN,
    ST_ISSUE,
    ST_WAIT,
    ST_CAP,
    ST_DONE
  } state_t;

  localparam logic [1:0] MODE_LFSR  = 2'd0;
  localparam logic [1:0] MODE_WALK  = 2'd1;
  localparam logic [1:0] MODE_FIXED = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int CNT_W = 16;

  function automatic int rec_width(input int w);
    return 3 * w + 6;
  endfunction

  function automatic int rec_y_lsb(input int w);
    return (w > 0) ? 0 : 0;
  endfunction

  function automatic int rec_ovf_bit(input int w);
    return w;
  endfunction

  function automatic int rec_err_bit(input int w);
    return w + 1;
  endfunction

  function automatic int rec_round_lsb(input int w);
    return w + 2;
  endfunction

  function automatic int rec_sel_lsb(input int w);
    return w + 4;
  endfunction

  function automatic int rec_b_lsb(input int w);
    return w + 6;
  endfunction

  function automatic int rec_a_lsb(input int w);
    return 2 * w + 6;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fpu_pattern_engine_fifo.sv
// ---------------------------------------------------------------------------
// fpu_pattern_engine_fifo
//   Show-ahead capture FIFO holding completed FPU operation records.
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   synchronous, active-high; empties the FIFO
//   push       in   write push_data (refused when full)
//   push_data  in   record to store
//   pop        in   drop head entry (ignored when empty)
//   head       out  current head entry, valid while empty==0
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  occupancy, 0..DEPTH
//
// Full/empty come straight from the registered count, so a pop on a full
// FIFO only frees the slot for a push on the following cycle.
// ---------------------------------------------------------------------------
module fpu_pattern_engine_fifo #(
  parameter int WIDTH_REC = 102,
  parameter int DEPTH     = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     push,
  input  logic [WIDTH_REC-1:0]     push_data,
  input  logic                     pop,
  output logic [WIDTH_REC-1:0]     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH_REC-1:0] mem [DEPTH];
  logic [PW-1:0]        wptr;
  logic [PW-1:0]        rptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/fpu_pattern_engine.sv
// ---------------------------------------------------------------------------
// fpu_pattern_engine
//   Stimulus/response engine for FPU bring-up. Generates operand pairs
//   (LFSR, walking-one or fixed), issues them with a one-cycle start pulse,
//   waits LATENCY cycles and captures {A,B,Sel,round,Error,Overflow,Y} into
//   a show-ahead FIFO for readout.
//
// Ports
//   Clock, Reset        clock; synchronous active-high reset
//   run                 start a campaign (only honoured in IDLE)
//   mode                0 LFSR, 1 walking-one, 2 fixed, 3 same as 0
//   num_ops             operations in the campaign (0 -> straight to DONE)
//   A, B, Sel, round    operands/controls to the FPU, held until capture
//   start               one-cycle issue pulse
//   Y, Error, Overflow  FPU response
//   rd_en               pop FIFO head
//   rd_valid, rd_data   FIFO head (show-ahead)
//   fifo_cnt            FIFO occupancy
//   busy, done          status; done pulses on DONE -> IDLE
//   op_cnt, err_cnt,    per-campaign statistics, saturating
//   ovf_cnt
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for run
//   ST_GEN   | compute and load next operand pair, raise start
//   ST_ISSUE | start high for this cycle, arm latency counter
//   ST_WAIT  | count down FPU latency
//   ST_CAP   | push result when FIFO has room, else hold
//   ST_DONE  | campaign finished, pulse done on exit
// ---------------------------------------------------------------------------
module fpu_pattern_engine
  import fpu_pattern_engine_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          DEPTH   = 16,
  parameter int          LATENCY = 4,
  parameter logic [31:0] SEED    = 32'hACE1_2468,
  parameter logic [31:0] FIX_A   = 32'h3F80_0000,
  parameter logic [31:0] FIX_B   = 32'h4000_0000
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        run,
  input  logic [1:0]                  mode,
  input  logic [15:0]                 num_ops,
  output logic [WIDTH-1:0]            A,
  output logic [WIDTH-1:0]            B,
  output logic [1:0]                  Sel,
  output logic [1:0]                  round,
  output logic                        start,
  input  logic [WIDTH-1:0]            Y,
  input  logic                        Error,
  input  logic                        Overflow,
  input  logic                        rd_en,
  output logic                        rd_valid,
  output logic [3*WIDTH+5:0]          rd_data,
  output logic [$clog2(DEPTH):0]      fifo_cnt,
  output logic                        busy,
  output logic                        done,
  output logic [15:0]                 op_cnt,
  output logic [15:0]                 err_cnt,
  output logic [15:0]                 ovf_cnt
);

  localparam int REC_W = rec_width(WIDTH);
  localparam int LAT_W = $clog2(LATENCY + 1);

  localparam logic [WIDTH-1:0] TAPS      = WIDTH'(LFSR_TAPS);
  localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_INIT = (SEED_W == '0) ? WIDTH'(1) : SEED_W;
  localparam logic [WIDTH-1:0] FIX_A_W   = WIDTH'(FIX_A);
  localparam logic [WIDTH-1:0] FIX_B_W   = WIDTH'(FIX_B);

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  state_t             state;
  logic [1:0]         mode_r;
  logic [15:0]        num_r;
  logic [15:0]        op_idx;
  logic [LAT_W-1:0]   wcnt;
  logic [WIDTH-1:0]   lfsr;

  logic [WIDTH-1:0]   lfsr_a;
  logic [WIDTH-1:0]   lfsr_b;
  logic [15:0]        walk_pos;
  logic [WIDTH-1:0]   walk_a;

  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic [REC_W-1:0]   push_data;

  assign lfsr_a   = lfsr_step(lfsr);
  assign lfsr_b   = lfsr_step(lfsr_a);
  assign walk_pos = op_idx % 16'(WIDTH);
  assign walk_a   = WIDTH'(1) << walk_pos;

  assign busy      = (state != ST_IDLE);
  assign push      = (state == ST_CAP) && !fifo_full;
  assign push_data = {A, B, Sel, round, Error, Overflow, Y};
  assign rd_valid  = !fifo_empty;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= ST_IDLE;
      mode_r  <= MODE_LFSR;
      num_r   <= '0;
      op_idx  <= '0;
      wcnt    <= '0;
      lfsr    <= SEED_INIT;
      A       <= '0;
      B       <= '0;
      Sel     <= '0;
      round   <= '0;
      start   <= 1'b0;
      done    <= 1'b0;
      op_cnt  <= '0;
      err_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run) begin
            mode_r  <= mode;
            num_r   <= num_ops;
            op_idx  <= '0;
            op_cnt  <= '0;
            err_cnt <= '0;
            ovf_cnt <= '0;
            state   <= (num_ops == 16'd0) ? ST_DONE : ST_GEN;
          end
        end
        ST_GEN: begin
          case (mode_r)
            MODE_WALK: begin
              A <= walk_a;
              B <= ~walk_a;
            end
            MODE_FIXED: begin
              A <= FIX_A_W;
              B <= FIX_B_W;
            end
            MODE_LFSR, MODE_RSVD: begin
              // Two steps per op: A takes the first, B the second.
              A    <= lfsr_a;
              B    <= lfsr_b;
              lfsr <= lfsr_b;
            end
            default: begin
              A <= lfsr_a;
              B <= lfsr_b;
            end
          endcase
          Sel   <= op_idx[1:0];
          round <= op_idx[3:2];
          start <= 1'b1;
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          wcnt  <= LAT_W'(LATENCY);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          wcnt <= wcnt - LAT_W'(1);
          if (wcnt == LAT_W'(1)) state <= ST_CAP;
        end
        ST_CAP: begin
          // While the FIFO is full we simply stay here; the FPU holds its
          // outputs, so the capture inputs are re-sampled every cycle.
          if (!fifo_full) begin
            op_cnt <= sat_inc(op_cnt);
            if (Error)    err_cnt <= sat_inc(err_cnt);
            if (Overflow) ovf_cnt <= sat_inc(ovf_cnt);
            op_idx <= op_idx + 16'd1;
            state  <= ((op_idx + 16'd1) == num_r) ? ST_DONE : ST_GEN;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fpu_pattern_engine_fifo #(
    .WIDTH_REC (REC_W),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .Clock     (Clock),
    .Reset     (Reset),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_en),
    .head      (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_fpu_pattern_engine.sv
// ---------------------------------------------------------------------------
// tb_fpu_pattern_engine
//   Directed bench for fpu_pattern_engine (WIDTH=32, DEPTH=4, LATENCY=2).
//   The FPU stand-in answers Y = A + 1; Error/Overflow are looked up per
//   op index from bench-owned masks.
// ---------------------------------------------------------------------------
module tb_fpu_pattern_engine;
  import fpu_pattern_engine_pkg::*;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int RW = 3 * W + 6;

  localparam logic [31:0] FA = 32'h3F80_0000;
  localparam logic [31:0] FB = 32'h4000_0000;

  logic           Clock;
  logic           Reset;
  logic           run;
  logic [1:0]     mode;
  logic [15:0]    num_ops;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [1:0]     Sel;
  logic [1:0]     round;
  logic           start;
  logic [W-1:0]   Y;
  logic           Error;
  logic           Overflow;
  logic           rd_en;
  logic           rd_valid;
  logic [RW-1:0]  rd_data;
  logic [2:0]     fifo_cnt;
  logic           busy;
  logic           done;
  logic [15:0]    op_cnt;
  logic [15:0]    err_cnt;
  logic [15:0]    ovf_cnt;

  logic [3:0]     err_mask;
  logic [3:0]     ovf_mask;

  int nvec;
  int nfail;

  fpu_pattern_engine #(
    .WIDTH   (W),
    .DEPTH   (D),
    .LATENCY (2)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .run      (run),
    .mode     (mode),
    .num_ops  (num_ops),
    .A        (A),
    .B        (B),
    .Sel      (Sel),
    .round    (round),
    .start    (start),
    .Y        (Y),
    .Error    (Error),
    .Overflow (Overflow),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .fifo_cnt (fifo_cnt),
    .busy     (busy),
    .done     (done),
    .op_cnt   (op_cnt),
    .err_cnt  (err_cnt),
    .ovf_cnt  (ovf_cnt)
  );

  assign Y        = A + 32'd1;
  assign Error    = err_mask[Sel];
  assign Overflow = ovf_mask[Sel];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [RW-1:0] rec(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] s, input logic [1:0] r,
                                        input logic e, input logic o);
    logic [31:0] y;
    y = a + 32'd1;
    return {a, b, s, r, e, o, y};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp)
      else begin
        nfail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic pulse_run(input logic [1:0] m, input logic [15:0] n);
    mode    = m;
    num_ops = n;
    run     = 1'b1;
    cyc(1);
    run     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int c = 0; c < budget && !done; c++) cyc(1);
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic pop_chk(input string tag, input logic [RW-1:0] exp);
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, rd_data, exp);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  int            nstart;
  int            s0;
  int            s1;
  int            nseen;
  logic [2:0]    cnt_a;
  logic [2:0]    cnt_b;
  logic          got_done;
  logic [RW-1:0] first_e;
  logic [RW-1:0] mid_e;
  logic [RW-1:0] last_e;

  initial begin
    nvec     = 0;
    nfail    = 0;
    Reset    = 1'b1;
    run      = 1'b0;
    mode     = 2'd0;
    num_ops  = 16'd0;
    rd_en    = 1'b0;
    err_mask = 4'b0000;
    ovf_mask = 4'b0000;
    cyc(3);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_outs", {A, B, Sel, round, start, done, rd_valid}, 0);
    chk("rst_cnts", {fifo_cnt, op_cnt, err_cnt, ovf_cnt}, 0);
    Reset = 1'b0;
    cyc(1);

    // Test 1: LFSR campaign, issue timing, reset in WAIT of op 2
    pulse_run(2'd0, 16'd5);
    nstart = 0; s0 = -1; s1 = -1; cnt_a = '1; cnt_b = '1;
    for (int c = 0; c < 100 && nstart < 3; c++) begin
      cyc(1);
      if (c == 3) cnt_a = fifo_cnt;
      if (c == 4) cnt_b = fifo_cnt;
      if (start) begin
        if (nstart == 0) s0 = c;
        if (nstart == 1) s1 = c;
        nstart++;
      end
    end
    chk("t1_nstart", nstart, 3);
    chk("t1_first_start", s0, 0);
    chk("t1_op_period", s1, 5);
    chk("t1_cnt_before_push", cnt_a, 0);
    chk("t1_cnt_after_push", cnt_b, 1);
    cyc(1);
    chk("t1_wait_busy", busy, 1);
    chk("t1_wait_cnts", {fifo_cnt, op_cnt}, {3'd2, 16'd2});
    chk("t1_head_lfsr", rd_data, rec(32'h5670_9234, 32'h2B38_491A, 2'd0, 2'd0, 1'b0, 1'b0));
    Reset = 1'b1;
    cyc(1);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_fifo", {fifo_cnt, rd_valid}, 0);
    chk("t1_rst_start", start, 0);
    chk("t1_rst_opcnt", op_cnt, 0);
    chk("t1_rst_ab", {A, B}, 0);
    Reset = 1'b0;
    cyc(1);

    // Reserved mode behaves as LFSR; LFSR restarted from seed by reset
    pulse_run(2'd3, 16'd2);
    wait_done(100, "t1b");
    chk("t1b_cnts", {fifo_cnt, op_cnt}, {3'd2, 16'd2});
    pop_chk("t1b_e0", rec(32'h5670_9234, 32'h2B38_491A, 2'd0, 2'd0, 1'b0, 1'b0));
    pop_chk("t1b_e1", rec(32'h159C_248D, 32'h8AEE_1245, 2'd1, 2'd0, 1'b0, 1'b0));
    chk("t1b_empty", {fifo_cnt, rd_valid}, 0);

    // Test 2: fixed mode, 3 ops; a run while busy is ignored
    pulse_run(2'd2, 16'd3);
    cyc(3);
    pulse_run(2'd1, 16'd9);
    wait_done(100, "t2");
    cyc(1);
    chk("t2_done_once", done, 0);
    chk("t2_idle", busy, 0);
    chk("t2_cnts", {fifo_cnt, op_cnt}, {3'd3, 16'd3});
    pop_chk("t2_e0", rec(FA, FB, 2'd0, 2'd0, 1'b0, 1'b0));
    pop_chk("t2_e1", rec(FA, FB, 2'd1, 2'd0, 1'b0, 1'b0));
    pop_chk("t2_e2", rec(FA, FB, 2'd2, 2'd0, 1'b0, 1'b0));

    // Test 3: walking-one, 34 ops, continuous readout
    rd_en = 1'b1;
    pulse_run(2'd1, 16'd34);
    nseen = 0; got_done = 1'b0;
    first_e = '0; mid_e = '0; last_e = '0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      cyc(1);
      if (done) got_done = 1'b1;
      else if (rd_valid) begin
        if (nseen == 0)  first_e = rd_data;
        if (nseen == 31) mid_e   = rd_data;
        if (nseen == 33) last_e  = rd_data;
        nseen++;
      end
    end
    rd_en = 1'b0;
    chk("t3_done", got_done, 1);
    chk("t3_nseen", nseen, 34);
    chk("t3_opcnt", op_cnt, 34);
    chk("t3_op0", first_e, rec(32'h0000_0001, 32'hFFFF_FFFE, 2'd0, 2'd0, 1'b0, 1'b0));
    chk("t3_op31", mid_e, rec(32'h8000_0000, 32'h7FFF_FFFF, 2'd3, 2'd3, 1'b0, 1'b0));
    chk("t3_op33", last_e, rec(32'h0000_0002, 32'hFFFF_FFFD, 2'd1, 2'd0, 1'b0, 1'b0));
    chk("t3_empty", fifo_cnt, 0);

    // Test 4: FIFO full stall, pop frees slot one cycle later
    pulse_run(2'd2, 16'd6);
    for (int c = 0; c < 200 && fifo_cnt != 3'd4; c++) cyc(1);
    cyc(6);
    chk("t4_full_cnt", fifo_cnt, 4);
    chk("t4_stall_busy", {busy, start}, 2'b10);
    chk("t4_stall_opcnt", op_cnt, 4);
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
    chk("t4_pop_cnt", fifo_cnt, 3);
    chk("t4_pop_opcnt", op_cnt, 4);
    chk("t4_pop_head", rd_data, rec(FA, FB, 2'd1, 2'd0, 1'b0, 1'b0));
    cyc(1);
    chk("t4_push_cnt", fifo_cnt, 4);
    chk("t4_push_opcnt", op_cnt, 5);
    rd_en = 1'b1;
    wait_done(100, "t4");
    rd_en = 1'b0;
    chk("t4_final", {fifo_cnt, op_cnt}, {3'd0, 16'd6});

    // Test 5: error/overflow statistics and record flags
    err_mask = 4'b1010;
    ovf_mask = 4'b0100;
    pulse_run(2'd2, 16'd4);
    wait_done(100, "t5");
    chk("t5_errcnt", err_cnt, 2);
    chk("t5_ovfcnt", ovf_cnt, 1);
    chk("t5_fifo", fifo_cnt, 4);
    chk("t5_err_bit", rd_data[rec_err_bit(W)], 0);
    for (int k = 0; k < 4; k++)
      pop_chk("t5_e", rec(FA, FB, 2'(k), 2'd0, err_mask[k], ovf_mask[k]));
    err_mask = 4'b0000;
    ovf_mask = 4'b0000;

    // Test 6: empty campaign
    pulse_run(2'd0, 16'd0);
    chk("t6_c1", {done, busy, start}, 3'b010);
    cyc(1);
    chk("t6_c2", {done, busy, start}, 3'b100);
    chk("t6_cnts", {fifo_cnt, op_cnt, err_cnt, ovf_cnt}, 0);
    cyc(1);
    chk("t6_c3", {done, start}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
